// File: rtl/wr_port_sched_pkg.sv
// Shared definitions for the write-port scheduler and its round-robin picker.
// Holds the FSM encoding, bus widths and the mod-3 pointer wrap helper.
package wr_port_sched_pkg;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned MASK_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Reduce a small sum (0..5) modulo 3; a pointer value of 3 behaves like 0.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return 2'((v >= 3'd3) ? (v - 3'd3) : v);
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: first active request at or after ptr wins.
// Shared by the read- and write-side schedulers.
module rr_pick3
  import wr_port_sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] onehot,
  output logic [1:0] idx
);

  logic       found;
  logic [1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned off = 0; off < 3; off++) begin
      cand = wrap3({1'b0, ptr} + 3'(off));
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/wr_port_sched.sv
// Round-robin write scheduler: shares one line-write manager between three requesters,
// latches the winner's line, issues one start pulse and holds the grant until the response.
module wr_port_sched
  import wr_port_sched_pkg::*;
#(
  parameter int unsigned TMO_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [LINE_W-1:0] wdata0,
  input  logic [LINE_W-1:0] wdata1,
  input  logic [LINE_W-1:0] wdata2,
  input  logic [MASK_W-1:0] mask0,
  input  logic [MASK_W-1:0] mask1,
  input  logic [MASK_W-1:0] mask2,
  output logic              gnt0,
  output logic              gnt1,
  output logic              gnt2,
  output logic              done0,
  output logic              done1,
  output logic              done2,
  output logic              err0,
  output logic              err1,
  output logic              err2,
  output logic              wstart_rq,
  output logic [ADDR_W-1:0] win_addr,
  output logic [LINE_W-1:0] in_wdata,
  output logic [MASK_W-1:0] in_mask,
  input  logic              finish_wresp,
  output logic              tmo_sticky
);

  sched_state_e      state_q, state_d;

  logic [NREQ-1:0]   req_vec;
  logic [NREQ-1:0]   pick_onehot;
  logic [1:0]        pick_idx;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              err_flag_q, err_flag_d;
  logic              tmo_sticky_q, tmo_sticky_d;
  logic [TMO_W-1:0]  wdog_q, wdog_d, wdog_inc;
  logic              timeout;

  logic [ADDR_W-1:0] addr_q, addr_d, addr_sel;
  logic [LINE_W-1:0] wdata_q, wdata_d, wdata_sel;
  logic [MASK_W-1:0] mask_q, mask_d, mask_sel;

  logic [NREQ-1:0]   done_vec, err_vec;

  assign req_vec = {req2, req1, req0};

  rr_pick3 u_pick (
    .req    (req_vec),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign wdog_inc = wdog_q + TMO_W'(1);
  // Fires on the WAIT cycle whose increment would land on all-ones.
  assign timeout  = &wdog_inc;

  always_comb begin
    case (pick_idx)
      2'd1: begin
        addr_sel  = addr1;
        wdata_sel = wdata1;
        mask_sel  = mask1;
      end
      2'd2: begin
        addr_sel  = addr2;
        wdata_sel = wdata2;
        mask_sel  = mask2;
      end
      default: begin
        addr_sel  = addr0;
        wdata_sel = wdata0;
        mask_sel  = mask0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. finish_wresp only matters in WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|req_vec) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (finish_wresp || timeout) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: winner latch, watchdog, round-robin pointer.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
    gnt_d        = gnt_q;
    err_flag_d   = err_flag_q;
    tmo_sticky_d = tmo_sticky_q;
    wdog_d       = wdog_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          gnt_d      = pick_onehot;
          win_d      = pick_idx;
          addr_d     = addr_sel & ~ADDR_W'(15);
          wdata_d    = wdata_sel;
          mask_d     = mask_sel;
          err_flag_d = 1'b0;
        end
      end
      ST_START: wdog_d = '0;
      ST_WAIT: begin
        wdog_d = wdog_inc;
        if (!finish_wresp && timeout) begin
          err_flag_d   = 1'b1;
          tmo_sticky_d = 1'b1;
        end
      end
      ST_DONE: begin
        gnt_d    = '0;
        rr_ptr_d = wrap3({1'b0, win_q} + 3'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      win_q        <= '0;
      gnt_q        <= '0;
      err_flag_q   <= 1'b0;
      tmo_sticky_q <= 1'b0;
      wdog_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      win_q        <= win_d;
      gnt_q        <= gnt_d;
      err_flag_q   <= err_flag_d;
      tmo_sticky_q <= tmo_sticky_d;
      wdog_q       <= wdog_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
    end
  end

  // Outputs decoded from registered state; the grant is still held during DONE.
  always_comb begin
    wstart_rq = (state_q == ST_START);
    done_vec  = (state_q == ST_DONE) ? gnt_q : '0;
    err_vec   = done_vec & {NREQ{err_flag_q}};
  end

  assign {gnt2, gnt1, gnt0}    = gnt_q;
  assign {done2, done1, done0} = done_vec;
  assign {err2, err1, err0}    = err_vec;
  assign win_addr              = addr_q;
  assign in_wdata              = wdata_q;
  assign in_mask               = mask_q;
  assign tmo_sticky            = tmo_sticky_q;

endmodule

// File: tb/tb_wr_port_sched.sv
// Directed bench for wr_port_sched with a 4-bit watchdog (timeout after 15 WAIT cycles).
module tb_wr_port_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, req2;
  logic [31:0]  addr0, addr1, addr2;
  logic [127:0] wdata0, wdata1, wdata2;
  logic [15:0]  mask0, mask1, mask2;
  logic         gnt0, gnt1, gnt2;
  logic         done0, done1, done2;
  logic         err0, err1, err2;
  logic         wstart_rq;
  logic [31:0]  win_addr;
  logic [127:0] in_wdata;
  logic [15:0]  in_mask;
  logic         finish_wresp;
  logic         tmo_sticky;

  logic [2:0] gnt_v, done_v, err_v;
  assign gnt_v  = {gnt2, gnt1, gnt0};
  assign done_v = {done2, done1, done0};
  assign err_v  = {err2, err1, err0};

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wr_port_sched #(.TMO_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req0),
    .req1         (req1),
    .req2         (req2),
    .addr0        (addr0),
    .addr1        (addr1),
    .addr2        (addr2),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .wdata2       (wdata2),
    .mask0        (mask0),
    .mask1        (mask1),
    .mask2        (mask2),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .gnt2         (gnt2),
    .done0        (done0),
    .done1        (done1),
    .done2        (done2),
    .err0         (err0),
    .err1         (err1),
    .err2         (err2),
    .wstart_rq    (wstart_rq),
    .win_addr     (win_addr),
    .in_wdata     (in_wdata),
    .in_mask      (in_mask),
    .finish_wresp (finish_wresp),
    .tmo_sticky   (tmo_sticky)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: wait for the start pulse, return finish_wresp fin_delay cycles later,
  // and report what was seen at start and in the done cycle. Leaves the bench in DONE.
  task automatic serve(input int fin_delay, output logic [2:0] g, output logic [2:0] d,
                       output logic [2:0] e, output bit ok);
    ok = 1'b0;
    g  = '0;
    d  = '0;
    e  = '0;
    for (int i = 0; i < 8 && !wstart_rq; i++) tick();
    if (!wstart_rq) return;
    g = gnt_v;
    repeat (fin_delay) tick();
    finish_wresp = 1'b1;
    tick();
    finish_wresp = 1'b0;
    d  = done_v;
    e  = err_v;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if (gnt_v !== 3'b000 || done_v !== 3'b000 || err_v !== 3'b000 || wstart_rq !== 1'b0)
      $display("FAIL reset_ctrl gnt=%b done=%b err=%b wstart=%b, want all 0",
               gnt_v, done_v, err_v, wstart_rq);
    else n_pass++;
    n_total++;
    if (win_addr !== 32'h0 || in_wdata !== 128'h0 || in_mask !== 16'h0 || tmo_sticky !== 1'b0)
      $display("FAIL reset_data addr=%h data=%h mask=%h sticky=%b, want all 0",
               win_addr, in_wdata, in_mask, tmo_sticky);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int nws   = 0;
    bit early = 1'b0;
    addr1  = 32'h0000_1234;
    wdata1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    mask1  = 16'h00F0;
    req1   = 1'b1;
    tick();
    n_total++;
    if (gnt_v !== 3'b010 || wstart_rq !== 1'b1)
      $display("FAIL single_grant gnt=%b wstart=%b, want 010/1", gnt_v, wstart_rq);
    else n_pass++;
    n_total++;
    if (win_addr !== 32'h0000_1230 || in_mask !== 16'h00F0 || in_wdata !== wdata1)
      $display("FAIL single_latch addr=%h mask=%h data=%h, want 00001230/00f0/%h",
               win_addr, in_mask, in_wdata, wdata1);
    else n_pass++;
    nws = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (wstart_rq) nws++;
      if (done_v !== 3'b000) early = 1'b1;
    end
    finish_wresp = 1'b1;
    tick();
    finish_wresp = 1'b0;
    if (wstart_rq) nws++;
    n_total++;
    if (done_v !== 3'b010 || err_v !== 3'b000 || gnt_v !== 3'b010)
      $display("FAIL single_done done=%b err=%b gnt=%b, want 010/000/010", done_v, err_v, gnt_v);
    else n_pass++;
    n_total++;
    if (nws != 1 || early)
      $display("FAIL single_pulses wstart_count=%0d early_done=%b, want 1/0", nws, early);
    else n_pass++;
    req1 = 1'b0;
    tick();
    n_total++;
    if (gnt_v !== 3'b000 || done_v !== 3'b000)
      $display("FAIL single_release gnt=%b done=%b, want 000/000", gnt_v, done_v);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] seen[$];
    logic [2:0] exp_g;
    bit         multi   = 1'b0;
    bit         prev_ws = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    req2  = 1'b1;
    for (int c = 0; c < 60 && seen.size() < 6; c++) begin
      tick();
      finish_wresp = prev_ws;
      if ((gnt_v & (gnt_v - 3'd1)) != 3'b000) multi = 1'b1;
      if (wstart_rq) seen.push_back(gnt_v);
      prev_ws = wstart_rq;
    end
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      n_total++;
      if (k >= seen.size() || seen[k] !== exp_g)
        $display("FAIL rr_order_%0d got=%b want=%b (grants seen=%0d)",
                 k, (k < seen.size()) ? seen[k] : 3'bxxx, exp_g, seen.size());
      else n_pass++;
    end
    n_total++;
    if (multi) $display("FAIL rr_onehot multiple grants seen=1, want 0");
    else n_pass++;
    tick();
    finish_wresp = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    req2 = 1'b0;
    tick();
    finish_wresp = 1'b0;
    n_total++;
    if (done_v !== 3'b100)
      $display("FAIL rr_drop_done done=%b, want 100", done_v);
    else n_pass++;
    tick();
  endtask

  task automatic test_rr_ptr();
    logic [2:0] g, d, e;
    bit ok;
    req0 = 1'b1;
    serve(1, g, d, e, ok);
    n_total++;
    if (!ok || g !== 3'b001 || d !== 3'b001)
      $display("FAIL ptr_prime ok=%b gnt=%b done=%b, want 1/001/001", ok, g, d);
    else n_pass++;
    req0 = 1'b0;
    tick();
    req0 = 1'b1;
    req2 = 1'b1;
    serve(1, g, d, e, ok);
    n_total++;
    if (!ok || g !== 3'b100 || d !== 3'b100)
      $display("FAIL ptr_first ok=%b gnt=%b done=%b, want 1/100/100", ok, g, d);
    else n_pass++;
    req2 = 1'b0;
    tick();
    serve(1, g, d, e, ok);
    n_total++;
    if (!ok || g !== 3'b001 || d !== 3'b001)
      $display("FAIL ptr_second ok=%b gnt=%b done=%b, want 1/001/001", ok, g, d);
    else n_pass++;
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    logic [2:0] g, d, e;
    bit ok;
    int nwait = 0;
    req1 = 1'b1;
    tick();
    n_total++;
    if (wstart_rq !== 1'b1 || gnt_v !== 3'b010)
      $display("FAIL tmo_start wstart=%b gnt=%b, want 1/010", wstart_rq, gnt_v);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done_v !== 3'b000) break;
      nwait++;
    end
    n_total++;
    if (nwait != 15)
      $display("FAIL tmo_wait_cycles got=%0d want=15", nwait);
    else n_pass++;
    n_total++;
    if (done_v !== 3'b010 || err_v !== 3'b010 || tmo_sticky !== 1'b1)
      $display("FAIL tmo_done done=%b err=%b sticky=%b, want 010/010/1",
               done_v, err_v, tmo_sticky);
    else n_pass++;
    req1 = 1'b0;
    tick();
    n_total++;
    if (err_v !== 3'b000 || tmo_sticky !== 1'b1)
      $display("FAIL tmo_sticky err=%b sticky=%b, want 000/1", err_v, tmo_sticky);
    else n_pass++;
    req2 = 1'b1;
    serve(2, g, d, e, ok);
    n_total++;
    if (!ok || g !== 3'b100 || d !== 3'b100 || e !== 3'b000 || tmo_sticky !== 1'b1)
      $display("FAIL tmo_recover ok=%b gnt=%b done=%b err=%b sticky=%b, want 1/100/100/000/1",
               ok, g, d, e, tmo_sticky);
    else n_pass++;
    req2 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit bad = 1'b0;
    addr0  = 32'h0000_ABC8;
    wdata0 = 128'hA0A0_B1B1_C2C2_D3D3_E4E4_F5F5_0606_1717;
    mask0  = 16'h0F0F;
    req0   = 1'b1;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_total++;
    if (gnt_v !== 3'b000 || done_v !== 3'b000 || err_v !== 3'b000 || wstart_rq !== 1'b0 ||
        win_addr !== 32'h0 || in_wdata !== 128'h0 || in_mask !== 16'h0 || tmo_sticky !== 1'b0)
      $display("FAIL midrst_clear gnt=%b done=%b err=%b wstart=%b addr=%h mask=%h sticky=%b, want 0",
               gnt_v, done_v, err_v, wstart_rq, win_addr, in_mask, tmo_sticky);
    else n_pass++;
    rst_n = 1'b1;
    req0  = 1'b0;
    finish_wresp = 1'b1;
    tick();
    finish_wresp = 1'b0;
    if (done_v !== 3'b000 || gnt_v !== 3'b000 || err_v !== 3'b000) bad = 1'b1;
    tick();
    if (done_v !== 3'b000 || gnt_v !== 3'b000 || err_v !== 3'b000) bad = 1'b1;
    n_total++;
    if (bad) $display("FAIL midrst_no_done stray output seen=1, want 0");
    else n_pass++;
    req1 = 1'b1;
    tick();
    n_total++;
    if (gnt_v !== 3'b010 || wstart_rq !== 1'b1)
      $display("FAIL midrst_idle gnt=%b wstart=%b, want 010/1", gnt_v, wstart_rq);
    else n_pass++;
    tick();
    finish_wresp = 1'b1;
    tick();
    finish_wresp = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_ignore_finish();
    logic [127:0] pat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bit bad = 1'b0;
    finish_wresp = 1'b1;
    tick();
    finish_wresp = 1'b0;
    n_total++;
    if (done_v !== 3'b000 || gnt_v !== 3'b000)
      $display("FAIL ign_idle done=%b gnt=%b, want 000/000", done_v, gnt_v);
    else n_pass++;
    addr2  = 32'hFFFF_FFFF;
    wdata2 = pat;
    mask2  = 16'hFFFF;
    req2   = 1'b1;
    tick();
    finish_wresp = 1'b1;
    tick();
    finish_wresp = 1'b0;
    n_total++;
    if (in_mask !== 16'hFFFF || in_wdata !== pat || win_addr !== 32'hFFFF_FFF0)
      $display("FAIL ign_latch mask=%h data=%h addr=%h, want ffff/%h/fffffff0",
               in_mask, in_wdata, win_addr, pat);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      if (done_v !== 3'b000 || gnt_v !== 3'b100) bad = 1'b1;
      tick();
    end
    n_total++;
    if (bad) $display("FAIL ign_start early completion seen=1, want 0");
    else n_pass++;
    finish_wresp = 1'b1;
    tick();
    finish_wresp = 1'b0;
    n_total++;
    if (done_v !== 3'b100 || err_v !== 3'b000)
      $display("FAIL ign_done done=%b err=%b, want 100/000", done_v, err_v);
    else n_pass++;
    req2 = 1'b0;
    tick();
    tick();
    n_total++;
    if (in_wdata !== pat || in_mask !== 16'hFFFF || gnt_v !== 3'b000)
      $display("FAIL ign_hold data=%h mask=%h gnt=%b, want %h/ffff/000",
               in_wdata, in_mask, gnt_v, pat);
    else n_pass++;
  endtask

  initial begin
    rst_n        = 1'b0;
    req0         = 1'b0;
    req1         = 1'b0;
    req2         = 1'b0;
    addr0        = 32'h0000_0100;
    addr1        = 32'h0000_0200;
    addr2        = 32'h0000_0300;
    wdata0       = 128'h0;
    wdata1       = 128'h0;
    wdata2       = 128'h0;
    mask0        = 16'h0;
    mask1        = 16'h0;
    mask2        = 16'h0;
    finish_wresp = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_ptr();
    test_timeout();
    test_reset_mid();
    test_ignore_finish();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout bench did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
